// File: rtl/i2c_wrbuf_master.sv
// I2C write master: bytes queue in a FIFO, and a FLUSH emits START, address+W, the queued bytes, STOP.
// Optional feature macro I2C_CLK_STRETCH_EN: the SCL-high quarters wait while a slave holds SCL low.
module i2c_wrbuf_master #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int CLK_DIV = 12
) (
  input  logic          CLK,
  input  logic          GSRn,
  input  logic          WR_EN,
  input  logic [7:0]    WR_DATA,
  input  logic          FLUSH,
  input  logic [6:0]    DEV_ADDR,
  output logic [AW:0]   COUNT,
  output logic          FULL,
  output logic          BUSY,
  output logic          DONE,
  output logic          NACK,
  output logic          SCL_OE,
  output logic          SDA_OE,
  input  logic          SCL_IN,
  input  logic          SDA_IN
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     qtr_q, qtr_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [AW:0]    remain_q, remain_d;
  logic [AW:0]    count_q, count_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic           nack_q, nack_d;
  logic           done_q, done_d;
  logic           busy_q;
  logic           scl_oe_q, sda_oe_q;
  logic [7:0]     shreg_q, shreg_d;
  logic [6:0]     addr_q, addr_d;
  logic           sda_smp_q, sda_smp_d;
  logic [7:0]     mem_q [DEPTH];
  logic           push, hold, tick;
  logic [AW:0]    pop_n;
  logic [1:0]     drv;

  // {scl_oe, sda_oe} for a given state/quarter; b is the bit being sent
  function automatic logic [1:0] line_drive(state_t s, logic [1:0] q, logic b);
    logic [1:0] r;
    r = 2'b00;
    case (s)
      S_START:         r = (q == 2'd0) ? 2'b00 : (q == 2'd1) ? 2'b01 : 2'b11;
      S_ADDR, S_DATA:  r = {(q == 2'd0) || (q == 2'd3), ~b};
      S_AACK, S_DACK:  r = {(q == 2'd0) || (q == 2'd3), 1'b0};
      S_STOP:          r = (q == 2'd0) ? 2'b11 : (q == 2'd1) ? 2'b01 : 2'b00;
      default:         r = 2'b00;
    endcase
    return r;
  endfunction

`ifdef I2C_CLK_STRETCH_EN
  assign hold = !SCL_IN && (qtr_q == 2'd2) &&
                (state_q inside {S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP});
`else
  logic scl_in_unused;
  assign scl_in_unused = SCL_IN;
  assign hold = 1'b0;
`endif

  assign tick   = (presc_q == PRESC_MAX) && !hold;
  assign push   = WR_EN && (count_q != DEPTH_C);
  assign rd_nxt = rd_ptr_q + AW'(1);

  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    presc_d   = presc_q;
    bitcnt_d  = bitcnt_q;
    remain_d  = remain_q;
    nack_d    = nack_q;
    done_d    = 1'b0;
    shreg_d   = shreg_q;
    addr_d    = addr_q;
    sda_smp_d = sda_smp_q;
    pop_n     = '0;

    if (state_q != S_IDLE)
      presc_d = tick ? '0 : (hold ? presc_q : presc_q + 1'b1);

    case (state_q)
      S_IDLE: begin
        qtr_d   = 2'd0;
        presc_d = '0;
        if (FLUSH) begin
          nack_d   = 1'b0;
          addr_d   = DEV_ADDR;
          remain_d = count_q;
          if (count_q == '0) done_d  = 1'b1;
          else               state_d = S_START;
        end
      end
      S_START: if (tick) begin
        if (qtr_q == 2'd2) begin
          state_d  = S_ADDR;
          qtr_d    = 2'd0;
          bitcnt_d = 3'd0;
          shreg_d  = {addr_q, 1'b0};
        end else qtr_d = qtr_q + 2'd1;
      end
      S_ADDR, S_DATA: if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
          if (bitcnt_q == 3'd7) state_d = (state_q == S_ADDR) ? S_AACK : S_DACK;
          else begin
            bitcnt_d = bitcnt_q + 3'd1;
            shreg_d  = {shreg_q[6:0], 1'b0};
          end
        end
      end
      S_AACK, S_DACK: if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd2) sda_smp_d = SDA_IN;
        if (qtr_q == 2'd3) begin
          // a NACK discards every byte of this transaction not yet popped
          if (sda_smp_q)                pop_n = remain_q;
          else if (state_q == S_DACK)   pop_n = (AW+1)'(1);
          remain_d = remain_q - pop_n;
          if (sda_smp_q) nack_d = 1'b1;
          if (sda_smp_q || (state_q == S_DACK && remain_q == (AW+1)'(1))) begin
            state_d = S_STOP;
          end else begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
            shreg_d  = (state_q == S_AACK) ? mem_q[rd_ptr_q] : mem_q[rd_nxt];
          end
        end
      end
      S_STOP: if (tick) begin
        if (qtr_q == 2'd2) begin
          state_d = S_IDLE;
          qtr_d   = 2'd0;
          done_d  = 1'b1;
        end else qtr_d = qtr_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase

    count_d  = count_q + (AW+1)'(push) - pop_n;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + pop_n[AW-1:0];
    drv      = line_drive(state_d, qtr_d, shreg_d[7]);
  end

  always_ff @(posedge CLK) begin
    if (!GSRn) begin
      state_q  <= S_IDLE;
      qtr_q    <= 2'd0;
      presc_q  <= '0;
      bitcnt_q <= 3'd0;
      remain_q <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      nack_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      qtr_q    <= qtr_d;
      presc_q  <= presc_d;
      bitcnt_q <= bitcnt_d;
      remain_q <= remain_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      nack_q   <= nack_d;
      done_q   <= done_d;
      busy_q   <= (state_d != S_IDLE);
      scl_oe_q <= drv[1];
      sda_oe_q <= drv[0];
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= WR_DATA;
    shreg_q   <= shreg_d;
    addr_q    <= addr_d;
    sda_smp_q <= sda_smp_d;
  end

  assign COUNT  = count_q;
  assign FULL   = (count_q == DEPTH_C);
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign NACK   = nack_q;
  assign SCL_OE = scl_oe_q;
  assign SDA_OE = sda_oe_q;

endmodule
